// File: rtl/definitions_pkg.sv
// Shared types for the signed-number display path: magnitudes, seven-segment
// glyph codes, BCD digits and the binary-to-BCD converter state encoding.
package definitions_pkg;

    typedef logic signed [15:0] int16_t;

    // Glyph codes understood by the seven-segment decoder; TEN renders the minus sign.
    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        ONE   = 4'd1,
        TWO   = 4'd2,
        THREE = 4'd3,
        FOUR  = 4'd4,
        FIVE  = 4'd5,
        SIX   = 4'd6,
        SEVEN = 4'd7,
        EIGHT = 4'd8,
        NINE  = 4'd9,
        TEN   = 4'd10,
        OFF   = 4'd15
    } segment_e;

    typedef logic [3:0] bcd_digit_t;

    localparam int BCD_DIGITS = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_e;

endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3
    import definitions_pkg::*;
(
    input  bcd_digit_t digit_i,
    output bcd_digit_t digit_o
);

    always_comb begin
        digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative binary-to-BCD converter (shift-add-3) with start/busy/done framing;
// the result and its sign glyph are held until the next conversion completes.
module bin_to_bcd_seq
    import definitions_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DIGITS = BCD_DIGITS
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [DATA_W-1:0]   i_data,
    input  segment_e            i_sign,
    output logic                o_busy,
    output logic                o_done,
    output logic [DIGITS*4-1:0] o_bcd,
    output segment_e            o_sign,
    output bcd_state_e          o_state
);

    localparam int BCD_W = DIGITS * 4;
    localparam int CNT_W = $clog2(DATA_W + 1);

    bcd_state_e          state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [BCD_W-1:0]    scratch_q, scratch_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    segment_e            sign_q, sign_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    segment_e            osign_q, osign_d;
    logic [BCD_W-1:0]    corr;
    logic [BCD_W+DATA_W-1:0] shifted;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_i (scratch_q[g*4 +: 4]),
            .digit_o (corr[g*4 +: 4])
        );
    end

    assign shifted = {corr, shift_q} << 1;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        bcd_d     = bcd_q;
        osign_d   = osign_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    shift_d   = i_data;
                    sign_d    = i_sign;
                    scratch_d = '0;
                    cnt_d     = CNT_W'(DATA_W);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = shifted[BCD_W+DATA_W-1:DATA_W];
                shift_d   = shifted[DATA_W-1:0];
                cnt_d     = cnt_q - CNT_W'(1);
                // Results are loaded with the final shift so they appear together with o_done.
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d   = shifted[BCD_W+DATA_W-1:DATA_W];
                    osign_d = sign_q;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            sign_q    <= OFF;
            bcd_q     <= '0;
            osign_q   <= OFF;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            sign_q    <= sign_d;
            bcd_q     <= bcd_d;
            osign_q   <= osign_d;
        end
    end

    assign o_busy  = (state_q == SHIFT) || (state_q == DONE);
    assign o_done  = (state_q == DONE);
    assign o_bcd   = bcd_q;
    assign o_sign  = osign_q;
    assign o_state = state_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: directed vectors plus a randomized sweep, checked by
// a queue-based scoreboard that a monitor drains on every o_done pulse.
module tb_bin_to_bcd_seq;
    import definitions_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] data;
    segment_e    sign;
    logic        busy;
    logic        done;
    logic [19:0] bcd;
    segment_e    osign;
    bcd_state_e  state;

    logic [23:0] exp_q[$];
    int          n_checks;
    int          n_fail;
    int          cycle;
    int          done_t[$];

    bin_to_bcd_seq #(.DATA_W(16), .DIGITS(5)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_data  (data),
        .i_sign  (sign),
        .o_busy  (busy),
        .o_done  (done),
        .o_bcd   (bcd),
        .o_sign  (osign),
        .o_state (state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int x;
        x = v;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst && done) begin
            logic [23:0] e;
            logic        digits_ok;
            done_t.push_back(cycle);
            if (exp_q.size() == 0) begin
                check("unexpected_done", {bcd, 4'(osign)}, 24'h0);
                if ({bcd, 4'(osign)} == 24'h0) begin
                    n_fail++;
                    $display("FAIL unexpected_done: o_done pulsed with empty queue (t=%0t)", $time);
                end
            end else begin
                e = exp_q.pop_front();
                check("bcd", 32'(bcd), 32'(e[23:4]));
                check("sign", 32'(osign), 32'(e[3:0]));
                digits_ok = 1'b1;
                for (int i = 0; i < 5; i++) if (bcd[i*4 +: 4] > 4'd9) digits_ok = 1'b0;
                check("digits_le9", 32'(digits_ok), 32'd1);
            end
        end
    end

    // driver: one framed conversion with timing checks
    task automatic convert(input logic [15:0] d, input segment_e s);
        int n;
        int busy_cnt;
        @(negedge clk);
        start = 1'b1;
        data  = d;
        sign  = s;
        exp_q.push_back({to_bcd(int'(d)), 4'(s)});
        @(negedge clk);
        start = 1'b0;
        data  = 16'($urandom);
        sign  = OFF;
        check("busy_rise", 32'(busy), 32'd1);
        n = 1;
        busy_cnt = busy ? 1 : 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (busy) busy_cnt++;
        end
        check("done_cycle", 32'(n), 32'd17);
        check("busy_cycles", 32'(busy_cnt), 32'd17);
        @(negedge clk);
        check("busy_fall", 32'(busy), 32'd0);
        check("done_single", 32'(done), 32'd0);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(done), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst   = 1'b1;
        start = 1'b1;
        data  = 16'd777;
        sign  = TEN;
        repeat (3) @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bcd", 32'(bcd), 32'd0);
        check("rst_sign", 32'(osign), 32'(OFF));
        check("rst_state", 32'(state), 32'(IDLE));

        convert(16'd12345, OFF);
        convert(16'h8000, TEN);
        check("hold_32768", 32'(bcd), 32'h32768);
        convert(16'hFFFF, OFF);
        convert(16'd0, OFF);
        check("hold_zero", 32'(bcd), 32'h00000);

        // start while busy is dropped
        @(negedge clk);
        start = 1'b1;
        data  = 16'd999;
        sign  = OFF;
        exp_q.push_back({20'h00999, 4'(OFF)});
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1;
        data  = 16'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done("done_999");
        repeat (25) @(negedge clk);
        check("hold_999", 32'(bcd), 32'h00999);
        check("no_queued_start", 32'(busy), 32'd0);

        // reset mid-conversion aborts without o_done
        @(negedge clk);
        start = 1'b1;
        data  = 16'd4321;
        sign  = TEN;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_bcd", 32'(bcd), 32'd0);
        check("abort_sign", 32'(osign), 32'(OFF));
        check("abort_busy", 32'(busy), 32'd0);
        repeat (25) @(negedge clk);
        check("abort_idle", 32'(state), 32'(IDLE));
        convert(16'd4321, TEN);
        check("after_abort", 32'(bcd), 32'h04321);

        // back-to-back with i_start held; data changes right after each capture
        done_t.delete();
        @(negedge clk);
        start = 1'b1;
        data  = 16'd1;
        sign  = OFF;
        exp_q.push_back({20'h00001, 4'(OFF)});
        @(negedge clk);
        data = 16'd10;
        exp_q.push_back({20'h00010, 4'(OFF)});
        repeat (18) @(negedge clk);
        data = 16'd100;
        exp_q.push_back({20'h00100, 4'(OFF)});
        repeat (18) @(negedge clk);
        start = 1'b0;
        data  = 16'hDEAD;
        wait_done("b2b_last_done");
        check("b2b_count", 32'(done_t.size()), 32'd3);
        if (done_t.size() == 3) begin
            check("b2b_gap1", 32'(done_t[1] - done_t[0]), 32'd18);
            check("b2b_gap2", 32'(done_t[2] - done_t[1]), 32'd18);
        end

        // randomized sweep against the decimal reference model
        for (int i = 0; i < 1000; i++) begin
            convert(16'($urandom_range(0, 65535)), ($urandom_range(0, 1) == 1) ? TEN : OFF);
        end

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
